// File: rtl/mult_pkg.sv
// Shared types and helpers for the mult_stream datapath.
// Optional output saturation is enabled by defining MULT_STREAM_SAT_EN.
package mult_pkg;

  localparam logic MODE_ELEM = 1'b0;
  localparam logic MODE_ACC  = 1'b1;

`ifdef MULT_STREAM_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  function automatic int acc_w(input int data_w, input int guard);
    return 2 * data_w + guard;
  endfunction

  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/mult_lane.sv
// One lane: S2 signed multiply, S3 accumulate/output register.
// With MULT_STREAM_SAT_EN defined the output is shifted and clipped; the accumulator is not.
module mult_lane
  import mult_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_W      = 20,
  parameter int SHIFT      = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          load_i,
  input  logic                          fire_i,
  input  logic                          first_i,
  input  logic                          mode_i,
  input  logic                          last_i,
  input  logic signed [DATA_WIDTH-1:0]  a_i,
  input  logic signed [DATA_WIDTH-1:0]  b_i,
  output logic signed [ACC_W-1:0]       data_o
);

  localparam int PW     = 2 * DATA_WIDTH;
  localparam int EW     = ACC_W - PW;
  localparam int SH_EFF = SAT_EN ? SHIFT : 0;

`ifdef MULT_STREAM_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
`endif

  function automatic logic signed [ACC_W-1:0] post_fn(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W-1:0] sh;
    sh = v >>> SH_EFF;
`ifdef MULT_STREAM_SAT_EN
    if (sh > SAT_MAX) begin
      post_fn = SAT_MAX;
    end else if (sh < SAT_MIN) begin
      post_fn = SAT_MIN;
    end else begin
      post_fn = sh;
    end
`else
    post_fn = sh;
`endif
  endfunction

  logic signed [PW-1:0]    prod_s;
  logic signed [ACC_W-1:0] sum_s;
  logic signed [ACC_W-1:0] prod_q;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] data_q;

  assign prod_s = PW'(a_i) * PW'(b_i);

  // The first beat of a frame ignores whatever the accumulator still holds.
  always_comb begin
    sum_s = prod_q;
    if (first_i) begin
      sum_s = prod_q;
    end else begin
      sum_s = acc_q + prod_q;
    end
  end

  // S2 product register, sign-extended into the accumulator width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q <= '0;
    end else if (load_i) begin
      prod_q <= {{EW{prod_s[PW-1]}}, prod_s};
    end
  end

  // S3 accumulate and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      data_q <= '0;
    end else if (fire_i) begin
      case (mode_i)
        MODE_ELEM: data_q <= post_fn(prod_q);
        MODE_ACC: begin
          if (last_i) begin
            data_q <= post_fn(sum_s);
            acc_q  <= '0;
          end else begin
            acc_q  <= sum_s;
          end
        end
        default: data_q <= data_q;
      endcase
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/mult_stream.sv
// Three-stage streaming LANES-wide signed multiplier with per-frame accumulate mode.
// Define MULT_STREAM_SAT_EN to shift by SHIFT and clip results to DATA_WIDTH.
module mult_stream
  import mult_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 16,
  parameter int ACC_GUARD  = 4,
  parameter int SHIFT      = 0
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        mode,
  input  logic                                        in_valid,
  output logic                                        in_ready,
  input  logic [LANES*DATA_WIDTH-1:0]                 in_a,
  input  logic [LANES*DATA_WIDTH-1:0]                 in_b,
  input  logic                                        in_last,
  output logic                                        out_valid,
  input  logic                                        out_ready,
  output logic [LANES*acc_w(DATA_WIDTH,ACC_GUARD)-1:0] out_data,
  output logic                                        out_last,
  output logic                                        out_ovf
);

  localparam int ACC_W = acc_w(DATA_WIDTH, ACC_GUARD);
  localparam int CNT_W = ACC_GUARD + 2;
  localparam logic [CNT_W-1:0] OVF_LIM = CNT_W'(1 << ACC_GUARD);
  localparam logic [CNT_W-1:0] CNT_MAX = OVF_LIM + CNT_W'(1);

  logic e1_s, e2_s, e3_s, fire_s, emit_s;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  logic                          in_first_q, frame_mode_q;
  logic                          s1_valid_q, s1_last_q, s1_mode_q, s1_first_q;
  logic [LANES*DATA_WIDTH-1:0]   s1_a_q, s1_b_q;
  logic                          s2_valid_q, s2_last_q, s2_mode_q, s2_first_q;
  logic                          out_valid_q, out_last_q, out_ovf_q;

  assign e3_s     = !out_valid_q || out_ready;
  assign e2_s     = !s2_valid_q || e3_s;
  assign e1_s     = !s1_valid_q || e2_s;
  assign in_ready = e1_s;
  assign fire_s   = e3_s && s2_valid_q;
  assign emit_s   = s2_valid_q && (s2_mode_q == MODE_ELEM || s2_last_q);

  // Beat count saturates one past the safe limit so overflow stays sticky.
  always_comb begin
    cnt_d = cnt_q;
    if (s2_first_q) begin
      cnt_d = CNT_W'(1);
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // S1 operand capture; frame mode is latched on the first beat only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_first_q   <= 1'b1;
      frame_mode_q <= MODE_ELEM;
      s1_valid_q   <= 1'b0;
      s1_last_q    <= 1'b0;
      s1_mode_q    <= MODE_ELEM;
      s1_first_q   <= 1'b0;
      s1_a_q       <= '0;
      s1_b_q       <= '0;
    end else if (e1_s) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_a_q     <= in_a;
        s1_b_q     <= in_b;
        s1_last_q  <= in_last;
        s1_first_q <= in_first_q;
        s1_mode_q  <= in_first_q ? mode : frame_mode_q;
        in_first_q <= in_last;
        if (in_first_q) begin
          frame_mode_q <= mode;
        end
      end
    end
  end

  // S2 control sidebands travelling alongside the lane products.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_last_q  <= 1'b0;
      s2_mode_q  <= MODE_ELEM;
      s2_first_q <= 1'b0;
    end else if (e2_s) begin
      s2_valid_q <= s1_valid_q;
      s2_last_q  <= s1_last_q;
      s2_mode_q  <= s1_mode_q;
      s2_first_q <= s1_first_q;
    end
  end

  // S3 output flags and per-frame beat counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_ovf_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      if (e3_s) begin
        out_valid_q <= emit_s;
        if (emit_s) begin
          out_last_q <= s2_last_q;
          out_ovf_q  <= (s2_mode_q == MODE_ACC) && (cnt_d > OVF_LIM);
        end
      end
      if (fire_s) begin
        cnt_q <= cnt_d;
      end
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    mult_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .ACC_W      (ACC_W),
      .SHIFT      (SHIFT)
    ) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (e2_s),
      .fire_i  (fire_s),
      .first_i (s2_first_q),
      .mode_i  (s2_mode_q),
      .last_i  (s2_last_q),
      .a_i     (s1_a_q[lane_lsb(l, DATA_WIDTH) +: DATA_WIDTH]),
      .b_i     (s1_b_q[lane_lsb(l, DATA_WIDTH) +: DATA_WIDTH]),
      .data_o  (out_data[lane_lsb(l, ACC_W) +: ACC_W])
    );
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_mult_stream.sv
// Directed/table-driven bench for mult_stream with an in-order result scoreboard.
module tb_mult_stream;

  localparam int DW = 8;
  localparam int L  = 16;
  localparam int G  = 4;
  localparam int AW = 2 * DW + G;
  localparam int SH = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              mode = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [L*DW-1:0]   in_a = '0;
  logic [L*DW-1:0]   in_b = '0;
  logic              in_last = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [L*AW-1:0]   out_data;
  logic              out_last;
  logic              out_ovf;

  mult_stream #(.DATA_WIDTH(DW), .LANES(L), .ACC_GUARD(G), .SHIFT(SH)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [L*AW-1:0] d;
    logic            last;
    logic            ovf;
    logic            chk_lat;
    logic [31:0]     cyc;
  } exp_t;

  typedef struct {
    int a0, b0, a1, b1, e0, e1;
    logic last;
  } vec_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [L*AW-1:0] act, input logic [L*AW-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  function automatic logic [AW-1:0] post(input logic signed [AW-1:0] v);
`ifdef MULT_STREAM_SAT_EN
    logic signed [AW-1:0] s;
    s = v >>> SH;
    if (s > 127) return AW'(127);
    else if (s < -128) return AW'(-128);
    else return s;
`else
    return v;
`endif
  endfunction

  function automatic logic [L*AW-1:0] model(input logic [L*DW-1:0] a, input logic [L*DW-1:0] b,
                                            input int n);
    logic [L*AW-1:0] r;
    int p;
    r = '0;
    for (int l = 0; l < L; l++) begin
      p = int'($signed(a[l*DW +: DW])) * int'($signed(b[l*DW +: DW])) * n;
      r[l*AW +: AW] = post(AW'(p));
    end
    return r;
  endfunction

  task automatic push_exp(input logic [L*AW-1:0] d, input logic lst, input logic ovf,
                          input logic lat, input int c);
    exp_t e;
    e.d = d; e.last = lst; e.ovf = ovf; e.chk_lat = lat; e.cyc = c;
    exp_q.push_back(e);
  endtask

  // Scoreboard: every accepted result must match the head of the expected queue.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_out: got data %h with no result pending", out_data);
      end else begin
        e = exp_q.pop_front();
        chk("out_data", out_data, e.d);
        chk("out_last", out_last, e.last);
        chk("out_ovf", out_ovf, e.ovf);
        if (e.chk_lat) chk("latency", cyc - int'(e.cyc), 3);
      end
    end
  end

  task automatic send(input logic m, input logic lst, input logic [L*DW-1:0] a,
                      input logic [L*DW-1:0] b, output int acc_cyc);
    mode = m; in_last = lst; in_a = a; in_b = b; in_valid = 1'b1;
    acc_cyc = -1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (in_ready) begin
        acc_cyc = cyc;
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (acc_cyc < 0) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: got no in_ready within 100 cycles, required acceptance");
    end
  endtask

  task automatic send_frame(input logic m, input int nb, input logic [L*DW-1:0] a,
                            input logic [L*DW-1:0] b, input logic toggle);
    int c;
    for (int k = 0; k < nb; k++)
      send((toggle && (k % 2 == 1)) ? ~m : m, k == nb - 1, a, b, c);
  endtask

  task automatic drain();
    for (int k = 0; k < 300 && exp_q.size() != 0; k++) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout: got %0d results outstanding, required 0", exp_q.size());
    end
    repeat (5) @(posedge clk);
    #1;
  endtask

  function automatic logic [L*DW-1:0] fill(input int a0, input int a1, input int rest_base,
                                           input int rest_step);
    logic [L*DW-1:0] v;
    v = '0;
    for (int l = 0; l < L; l++) v[l*DW +: DW] = DW'(rest_base + rest_step * l);
    v[0 +: DW] = DW'(a0);
    v[DW +: DW] = DW'(a1);
    return v;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish by 500us, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[6];
    logic [L*DW-1:0] va, vb;
    logic [L*AW-1:0] ed;
    int c, acc_n, occ;
    logic have, lst, fire, cons;

    tbl[0] = '{-128, -128, 127, -128, 16384, -16256, 1'b0};
    tbl[1] = '{127, 127, -128, 127, 16129, -16256, 1'b0};
    tbl[2] = '{0, 55, -1, -1, 0, 1, 1'b1};
    tbl[3] = '{12, -11, 100, 2, -132, 200, 1'b0};
    tbl[4] = '{-7, 9, 64, 64, -63, 4096, 1'b0};
    tbl[5] = '{1, -128, -128, 0, -128, 0, 1'b1};

    #3;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, '0);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_out_ovf", out_ovf, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", in_ready, 1'b1);

    // Elementwise table, back to back, with latency check.
    for (int i = 0; i < 6; i++) begin
      va = fill(tbl[i].a0, tbl[i].a1, i * 3 - 40, 5);
      vb = fill(tbl[i].b0, tbl[i].b1, 7 - i, -1);
      send(1'b0, tbl[i].last, va, vb, c);
      ed = model(va, vb, 1);
      ed[0 +: AW]  = post(AW'(tbl[i].e0));
      ed[AW +: AW] = post(AW'(tbl[i].e1));
      push_exp(ed, tbl[i].last, 1'b0, 1'b1, c);
    end
    drain();

    // Accumulate 4-beat frame with mode toggling mid-frame, then a 1-beat elementwise frame.
    va = fill(3, -2, -8, 1);
    vb = fill(5, 7, 3, 0);
    ed = model(va, vb, 4);
    ed[0 +: AW]  = post(AW'(60));
    ed[AW +: AW] = post(AW'(-56));
    push_exp(ed, 1'b1, 1'b0, 1'b0, 0);
    send_frame(1'b1, 4, va, vb, 1'b1);
    va = fill(-9, 11, 2, 3);
    vb = fill(10, -4, -5, 1);
    ed = model(va, vb, 1);
    ed[0 +: AW]  = post(AW'(-90));
    ed[AW +: AW] = post(AW'(-44));
    push_exp(ed, 1'b1, 1'b0, 1'b0, 0);
    send_frame(1'b0, 1, va, vb, 1'b0);

    // Frame-length boundaries: 16 beats (no ovf), 17 beats (ovf), then clean 2- and 1-beat frames.
    va = fill(1, 1, 1, 0);
    ed = model(va, va, 16);
    ed[0 +: AW] = post(AW'(16));
    push_exp(ed, 1'b1, 1'b0, 1'b0, 0);
    send_frame(1'b1, 16, va, va, 1'b0);
    va = fill(127, 127, 127, 0);
    ed = model(va, va, 17);
    ed[0 +: AW] = post(AW'(274193));
    push_exp(ed, 1'b1, 1'b1, 1'b0, 0);
    send_frame(1'b1, 17, va, va, 1'b0);
    va = fill(3, 3, 3, 0);
    vb = fill(4, 4, 4, 0);
    ed = model(va, vb, 2);
    ed[0 +: AW] = post(AW'(24));
    push_exp(ed, 1'b1, 1'b0, 1'b0, 0);
    send_frame(1'b1, 2, va, vb, 1'b0);
    va = fill(-5, -5, -5, 0);
    vb = fill(6, 6, 6, 0);
    ed = model(va, vb, 1);
    ed[0 +: AW] = post(AW'(-30));
    push_exp(ed, 1'b1, 1'b0, 1'b0, 0);
    send_frame(1'b1, 1, va, vb, 1'b0);
    drain();

    // Random backpressure over 1000 elementwise beats; in_ready tracked against occupancy.
    acc_n = 0; occ = 0; have = 1'b0; lst = 1'b0;
    for (int k = 0; k < 8000 && acc_n < 1000; k++) begin
      if (!have) begin
        for (int l = 0; l < L; l++) begin
          va[l*DW +: DW] = DW'($urandom_range(0, 255));
          vb[l*DW +: DW] = DW'($urandom_range(0, 255));
        end
        lst = ($urandom_range(0, 3) == 0);
        have = 1'b1;
      end
      in_valid = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      mode = 1'b0; in_last = lst; in_a = va; in_b = vb;
      @(negedge clk);
      chk("in_ready_bp", in_ready, (occ < 3) || out_ready);
      fire = in_valid && in_ready;
      cons = out_valid && out_ready;
      if (fire) begin
        push_exp(model(va, vb, 1), lst, 1'b0, 1'b0, 0);
        have = 1'b0;
        acc_n++;
      end
      occ = occ + int'(fire) - int'(cons);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    if (acc_n < 1000) begin
      n_cmp++; n_bad++;
      $display("FAIL bp_budget: got %0d beats accepted, required 1000", acc_n);
    end
    drain();

    // Reset in the middle of an accumulate frame.
    va = fill(9, 9, 9, 0);
    vb = fill(9, 9, 9, 0);
    send(1'b1, 1'b0, va, vb, c);
    send(1'b1, 1'b0, va, vb, c);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_out_data", out_data, '0);
    chk("midrst_out_last", out_last, 1'b0);
    chk("midrst_out_ovf", out_ovf, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst_in_ready", in_ready, 1'b1);
    va = fill(3, 3, 3, 0);
    vb = fill(5, 5, 5, 0);
    ed = model(va, vb, 2);
    ed[0 +: AW] = post(AW'(30));
    push_exp(ed, 1'b1, 1'b0, 1'b0, 0);
    send_frame(1'b1, 2, va, vb, 1'b0);
    drain();
    chk("queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mult_stream.md
Name: mult_stream

Overview:
- Pipelined, streaming successor to the combinational elementwise MULT block.
- LANES signed multipliers per beat, with valid/ready handshake and backpressure.
- Two modes per frame: elementwise product (one result per beat), or per-lane multiply-accumulate over a frame (one result per frame, as for a conv window dot product).
- Sits between the feature-map/weight buffers and the activation stage of the CNN datapath.

Parameters:
DATA_WIDTH, 8, signed operand width per lane
LANES, 16, parallel lanes per beat
ACC_GUARD, 4, accumulator guard bits; ACC_W = 2*DATA_WIDTH + ACC_GUARD; max safe frame length 2^ACC_GUARD beats
SHIFT, 0, arithmetic right shift applied to the result only when MULT_STREAM_SAT_EN is defined

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
mode  in  1  0 = elementwise, 1 = accumulate; sampled on the first beat of each frame
in_valid  in  1  input beat valid
in_ready  out  1  input beat accepted when in_valid && in_ready
in_a  in  LANES*DATA_WIDTH  signed operands; lane i at [(i+1)*DATA_WIDTH-1 -: DATA_WIDTH]
in_b  in  LANES*DATA_WIDTH  signed operands; same packing as in_a
in_last  in  1  last beat of frame
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_data  out  LANES*ACC_W  signed results; lane i at [(i+1)*ACC_W-1 -: ACC_W]
out_last  out  1  frame end marker for the result
out_ovf  out  1  accumulate-mode frame exceeded 2^ACC_GUARD beats; qualified by out_valid

Behaviour:
- Reset (async, rst_n=0): all stage valids, accumulators, beat counter, frame_mode and first-beat flag cleared/set-to-idle. out_valid=0, out_data=0, out_last=0, out_ovf=0. in_ready=1 on the first clk edge after release.
- Pipeline stages:
  - S1: register operands, last, mode.
  - S2: register LANES signed products, each 2*DATA_WIDTH bits, sign-extended to ACC_W.
  - S3: output/accumulate stage.
- Stage enables: e3 = !out_valid || out_ready; e2 = !s2_valid || e3; e1 = !s1_valid || e2; in_ready = e1 (combinational). No beat is dropped or duplicated under any stall pattern.
- Latency: an accepted beat, with out_ready held high, produces out_valid 3 cycles later. Full throughput is 1 beat/cycle.
- Frame tracking: a frame starts on the first beat after reset or after an in_last beat. frame_mode latches mode on that beat; mode changes mid-frame are ignored.
- Elementwise mode: every beat yields one result. out_data lane = a*b. out_last = that beat's in_last. out_ovf = 0.
- Accumulate mode, at S3 when e3:
  - sum = (first ? 0 : acc) + prod, per lane, wrapping two's complement in ACC_W.
  - Non-last beat: acc <= sum; out_valid is not raised for this beat.
  - Last beat: out_data <= sum, out_valid=1, out_last=1, first flag set, acc cleared.
  - A single-beat frame (in_last on the first beat) outputs its product directly.
- Beat counter: counts beats per frame, saturating at 2^ACC_GUARD+1. out_ovf=1 on the frame result if the count exceeded 2^ACC_GUARD; cleared at frame start.
- Simultaneous events: a new frame's first beat may enter S3 in the cycle after the previous frame's last beat. The first flag guarantees no accumulator bleed between frames.
- Reset mid-frame discards the partial accumulation; no result is emitted for that frame.

Optional Feature:
- Macro MULT_STREAM_SAT_EN.
- Defined: each lane result is arithmetically shifted right by SHIFT, then clipped to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1], then sign-extended into its ACC_W field. The clip is applied in the S3 output path only; the accumulator keeps full precision. Latency is unchanged.
- Undefined: raw ACC_W wrapped results; SHIFT is ignored.

Decomposition:
- Package mult_pkg holds:
  - localparam function for ACC_W;
  - mode encodings MODE_ELEM=1'b0, MODE_ACC=1'b1;
  - lane slice helper constants.
- Sub-module mult_lane: one lane's S2 multiply, S3 accumulate, and optional clip; instantiated LANES times via generate.
- Control (enables, frame/first flags, counter, ovf) stays in mult_stream.

Test Plan:
- Elementwise, LANES=16: random a,b with out_ready=1; lane0 a=-128, b=-128 -> 16384; lane1 a=127, b=-128 -> -16256. Each result arrives 3 cycles after acceptance, in order.
- Accumulate, 4-beat frame, lane0 a=3,b=5 every beat -> single out_valid, out_data lane0=60, out_last=1, out_ovf=0.
- Backpressure: random in_valid/out_ready toggling over 1000 elementwise beats -> scoreboard matches exactly, no drop or duplicate; in_ready=0 whenever the pipeline is full and out_ready=0.
- Frame overflow: ACC_GUARD=4, 17-beat accumulate frame, a=b=127 -> wrapped sum 274193 mod 2^20 as signed, out_ovf=1. The next 2-beat frame gives out_ovf=0 and the correct sum with no carry-over.
- Mode switch and reset: mode toggles mid-frame -> ignored. rst_n pulsed low mid-accumulate-frame -> outputs 0 immediately, no stale result afterwards, the next frame is correct.
- With MULT_STREAM_SAT_EN, SHIFT=4: elementwise 127*127=16129 -> shifted 1008 -> clipped 127; -128*127 -> -1016 -> -128.
